seg_scan_display: RTL
=====================

# seg_scan_display

Parametrised multi-digit, time-multiplexed 7-segment display driver for the board debug display. It shows PC, packet data or packet header in hex across NUM_DIGITS common-anode digits. A debounced DISP_SWITCH press cycles the display source. Each scan frame uses a coherent snapshot of the selected value, with inter-digit blanking against ghosting. It sits beside the core and replaces the single-digit toggling display.

## Interface
- NUM_DIGITS, 4: digits scanned, 1..8; displays NUM_DIGITS*4 LSBs of the selected value.
- PC_W, 5: PC width.
- PACKET_W, 38: packet width.
- DATA_W, 16: packet data field = PACKET_IN[DATA_W-1:0]; header = PACKET_IN[PACKET_W-1:DATA_W].
- SCAN_DIV, 12500: clock cycles per digit slot, >= BLANK_CYC+2.
- BLANK_CYC, 64: cycles all digits are off at the start of each slot.
- DEB_CYC, 500000: cycles DISP_SWITCH must be stable to be accepted.
- LZ_BLANK, 1: 1 = blank leading zero digits; digit 0 is never blanked.
- CLK in 1: system clock, all logic on rising edge.
- nRST in 1: asynchronous, active-low reset.
- DISP_SWITCH in 1: raw push button, asynchronous, active-high.
- PC in PC_W: program counter.
- PACKET_IN in PACKET_W: current packet.
- nHEX out 8: active-low segments {dp,g,f,e,d,c,b,a}, registered.
- nDIGIT out NUM_DIGITS: active-low digit enables, at most one low, registered.
- MODE out 2: current source, 0 = PC, 1 = data, 2 = header.

## Operation
- **Switch input:**
  - DISP_SWITCH is synchronised by a 2-FF synchroniser, then debounced.
  - Debounce: a counter restarts whenever the synchronised input differs from the accepted level.
  - The accepted level updates after DEB_CYC consecutive equal samples.
- **Mode:** each accepted 0->1 transition advances MODE 0->1->2->0. Value 3 is never produced.
- **Selected value:** PC, data field or header, zero-extended or truncated to NUM_DIGITS*4 bits.
- **Scan FSM, states BLANK and SHOW:**
  - BLANK: nDIGIT all ones, nHEX = 8'hFF for BLANK_CYC cycles, then SHOW.
  - SHOW: the current digit index is enabled for SCAN_DIV-BLANK_CYC cycles, then the index increments and the FSM returns to BLANK.
  - The index wraps from NUM_DIGITS-1 to 0.
- **Snapshot:**
  - The selected value and MODE are latched into a snapshot register on entry to BLANK of digit 0.
  - All digits of a frame show the same snapshot. A source change or mode change mid-frame appears from the next frame.
- **Decoding:**
  - Hex encoding: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, c=A7, d=A1, E=86, F=8E.
  - dp (bit 7) is low only on digit NUM_DIGITS-1 when the snapshot mode is 2.
- **Leading-zero blanking:** with LZ_BLANK=1, digit k>0 shows nHEX=8'hFF (digit still enabled) when all nibbles k..NUM_DIGITS-1 of the snapshot are zero. dp still applies.
- **Reset:**
  - nHEX = 8'hFF, nDIGIT = all ones, MODE = 0.
  - FSM in BLANK with digit index 0; snapshot 0; debounce accepted level 0, counter 0.
  - Reset mid-frame blanks immediately (asynchronous).

## Timing
- Frame = NUM_DIGITS*SCAN_DIV cycles. Each digit is dark for BLANK_CYC cycles and lit for SCAN_DIV-BLANK_CYC cycles.
- nHEX and nDIGIT change on the same clock edge; there is never a cycle with a new digit enable and old segments.
- Switch latency: 2 sync cycles + DEB_CYC cycles + 1 to MODE. Presses shorter than DEB_CYC are ignored.
- Press and frame wrap in the same cycle: the snapshot takes the old MODE, and the new MODE shows from the next frame.
- After nRST deasserts, the first digit 0 is lit at cycle BLANK_CYC+1.

## Structure
- **Shared package:** segment encoding function (nibble to nHEX), MODE encoding constants (MODE_PC, MODE_DATA, MODE_HDR), scan FSM state typedef.
- **Sub-module:** sw_debounce (sync + debounce counter, outputs a one-cycle rise pulse), parametrised by DEB_CYC, reusable for other buttons.
- **Counter widths:** derived with $clog2 of SCAN_DIV and DEB_CYC.

## Test plan
- **Reset values:** NUM_DIGITS=4, SCAN_DIV=20, BLANK_CYC=4, nRST low -> nHEX=FF, nDIGIT=4'b1111, MODE=0; after release, digit 0 enables at cycle 5.
- **PC display:** PC=5'h1A, LZ_BLANK=1 -> digit0 nHEX=88, digit1 F9, digits 2 and 3 FF; each slot preceded by 4 dark cycles.
- **Switch debounce:** DEB_CYC=10; 6-cycle pulse -> MODE stays 0; 15-cycle press -> MODE=1 after 13 cycles; three accepted presses -> MODE returns to 0.
- **Header mode:** MODE=2, PACKET_IN[37:16]=22'h00ABC -> digits show C, B, A, blank; dp low on digit 3 (nHEX=7F).
- **Snapshot coherence:** change PACKET_IN[15:0] from 16'h1234 to 16'hFFFF while digit 1 is lit -> digits 2 and 3 still show 2 and 1 (A4, F9); the next frame shows all 8E.
- **Async reset mid-frame:** nRST low while digit 2 is lit -> nDIGIT all ones with no clock edge; after release, the scan restarts at digit 0 with MODE=0.

Source files
------------

// File: rtl/seg_scan_display_pkg.sv
// seg_scan_display_pkg: shared mode codes, scan FSM states and hex-to-segment encoding.
package seg_scan_display_pkg;
  localparam logic [1:0] MODE_PC   = 2'd0;
  localparam logic [1:0] MODE_DATA = 2'd1;
  localparam logic [1:0] MODE_HDR  = 2'd2;
  typedef enum logic {ST_BLANK, ST_SHOW} scan_state_t;
  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off here and is applied by the caller.
  function automatic logic [7:0] seg_enc(input logic [3:0] n);
    case (n)
      4'h0: seg_enc = 8'hC0;
      4'h1: seg_enc = 8'hF9;
      4'h2: seg_enc = 8'hA4;
      4'h3: seg_enc = 8'hB0;
      4'h4: seg_enc = 8'h99;
      4'h5: seg_enc = 8'h92;
      4'h6: seg_enc = 8'h82;
      4'h7: seg_enc = 8'hF8;
      4'h8: seg_enc = 8'h80;
      4'h9: seg_enc = 8'h90;
      4'hA: seg_enc = 8'h88;
      4'hB: seg_enc = 8'h83;
      4'hC: seg_enc = 8'hA7;
      4'hD: seg_enc = 8'hA1;
      4'hE: seg_enc = 8'h86;
      default: seg_enc = 8'h8E;
    endcase
  endfunction
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-FF synchroniser plus debounce counter; one-cycle pulse on accepted 0->1.
// Ports: CLK, nRST (async active-low), i_sw raw button, o_rise registered rise pulse.
module sw_debounce #(
  parameter int DEB_CYC = 500000
) (
  input  logic CLK,
  input  logic nRST,
  input  logic i_sw,
  output logic o_rise
);
  localparam int CW = $clog2(DEB_CYC + 1);
  logic [1:0] r_sync;
  logic r_level;
  logic r_rise;
  logic [CW-1:0] r_cnt;
  logic w_diff;
  logic w_done;
  assign w_diff = r_sync[1] != r_level;
  // The sample that makes the count reach DEB_CYC is the accepting one.
  assign w_done = w_diff && r_cnt == CW'(DEB_CYC - 1);
  assign o_rise = r_rise;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_sw};
      r_cnt   <= (!w_diff || w_done) ? '0 : r_cnt + 1'b1;
      r_level <= w_done ? r_sync[1] : r_level;
      r_rise  <= w_done && r_sync[1];
    end
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed multi-digit 7-segment hex display with button-selected source.
// Ports: CLK, nRST (async active-low), DISP_SWITCH raw button, PC, PACKET_IN sources;
//        nHEX active-low segments, nDIGIT active-low digit enables, MODE current source.
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PC_W       = 5,
  parameter int PACKET_W   = 38,
  parameter int DATA_W     = 16,
  parameter int SCAN_DIV   = 12500,
  parameter int BLANK_CYC  = 64,
  parameter int DEB_CYC    = 500000,
  parameter int LZ_BLANK   = 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  DISP_SWITCH,
  input  logic [PC_W-1:0]       PC,
  input  logic [PACKET_W-1:0]   PACKET_IN,
  output logic [7:0]            nHEX,
  output logic [NUM_DIGITS-1:0] nDIGIT,
  output logic [1:0]            MODE
);
  localparam int VW = NUM_DIGITS * 4;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  logic w_rise;
  logic [1:0] r_mode;
  logic [1:0] r_snap_mode;
  scan_state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [IW-1:0] r_idx, w_idx_n;
  logic [VW-1:0] r_snap, w_sel;
  logic [7:0] r_nhex, w_nhex_n;
  logic [NUM_DIGITS-1:0] r_ndigit, w_ndigit_n;
  logic [3:0] w_nib;
  logic w_last, w_wrap, w_frame, w_lz, w_dp;
  sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
    .CLK   (CLK),
    .nRST  (nRST),
    .i_sw  (DISP_SWITCH),
    .o_rise(w_rise)
  );
  assign nHEX   = r_nhex;
  assign nDIGIT = r_ndigit;
  assign MODE   = r_mode;
  // Outputs are registered from the next-state view so nDIGIT and nHEX always switch together.
  always_comb begin
    w_last     = r_state == ST_BLANK ? r_cnt == CW'(BLANK_CYC - 1) : r_cnt == CW'(SCAN_DIV - BLANK_CYC - 1);
    w_state_n  = w_last ? (r_state == ST_BLANK ? ST_SHOW : ST_BLANK) : r_state;
    w_cnt_n    = w_last ? '0 : r_cnt + 1'b1;
    w_wrap     = w_last && r_state == ST_SHOW;
    w_frame    = w_wrap && r_idx == IW'(NUM_DIGITS - 1);
    w_idx_n    = !w_wrap ? r_idx : w_frame ? '0 : r_idx + 1'b1;
    w_nib      = r_snap[{w_idx_n, 2'b00} +: 4];
    // A digit is a leading zero when it and every more-significant nibble are zero.
    w_lz       = LZ_BLANK != 0 && w_idx_n != '0 && (r_snap >> {w_idx_n, 2'b00}) == '0;
    w_dp       = w_idx_n == IW'(NUM_DIGITS - 1) && r_snap_mode == MODE_HDR;
    w_nhex_n   = w_state_n != ST_SHOW ? 8'hFF : (w_lz ? 8'hFF : seg_enc(w_nib)) & (w_dp ? 8'h7F : 8'hFF);
    w_ndigit_n = w_state_n == ST_SHOW ? ~(NUM_DIGITS'(1) << w_idx_n) : '1;
    w_sel      = r_mode == MODE_PC   ? VW'(PC) :
                 r_mode == MODE_DATA ? VW'(PACKET_IN[DATA_W-1:0]) : VW'(PACKET_IN[PACKET_W-1:DATA_W]);
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_state     <= ST_BLANK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_mode      <= MODE_PC;
      r_snap      <= '0;
      r_snap_mode <= MODE_PC;
      r_nhex      <= 8'hFF;
      r_ndigit    <= '1;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_idx    <= w_idx_n;
      r_nhex   <= w_nhex_n;
      r_ndigit <= w_ndigit_n;
      r_mode   <= w_rise ? (r_mode == MODE_HDR ? MODE_PC : r_mode + 2'd1) : r_mode;
      // Snapshot on the edge entering digit 0's blank; a same-edge mode change lands next frame.
      if (w_frame) begin
        r_snap      <= w_sel;
        r_snap_mode <= r_mode;
      end
    end
endmodule
